// File: rtl/compare_seq_pkg.sv
// Shared constants for the sequential slice comparator: default widths and FSM encodings.
package compare_seq_pkg;

  localparam int N_DEF = 32;
  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/compare_seq_slice_cmp.sv
// Combinational W-bit unsigned slice compare; equality is an AND of per-bit XNORs.
module slice_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt
);

  logic [W-1:0] bit_eq;

  assign bit_eq = ~(a ^ b);
  assign eq     = &bit_eq;
  assign gt     = (a > b);

endmodule

// File: rtl/compare_seq.sv
// Multi-cycle magnitude comparator: scans W-bit slices from the MS end and stops at the
// first differing slice. Signed compares are mapped to unsigned by flipping the MSBs.
module compare_seq
  import compare_seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sgn,
  output logic         ready,
  output logic         done,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  localparam int S  = N / W;
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IW-1:0] IDX_MS = IW'(S - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic          gt_q, gt_d;

  logic [W-1:0]  a_slice, b_slice;
  logic          s_eq, s_gt;

  assign a_slice = a_q[idx_q*W +: W];
  assign b_slice = b_q[idx_q*W +: W];

  slice_cmp #(.W(W)) u_slice_cmp (
    .a  (a_slice),
    .b  (b_slice),
    .eq (s_eq),
    .gt (s_gt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d = a;
          b_d = b;
          // Offset-binary trick: flipping both MSBs turns signed order into unsigned order.
          if (sgn) begin
            a_d[N-1] = ~a[N-1];
            b_d[N-1] = ~b[N-1];
          end
          idx_d   = IDX_MS;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!s_eq) begin
          gt_d    = s_gt;
          lt_d    = ~s_gt;
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_MS;
      a_q     <= '0;
      b_q     <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign eq    = eq_q;
  assign lt    = lt_q;
  assign gt    = gt_q;

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq: hand-computed results and start-to-done latencies.
module tb_compare_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        sgn;
  logic        ready, done, eq, lt, gt;

  int n_tot = 0;
  int n_bad = 0;

  compare_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sgn   (sgn),
    .ready (ready),
    .done  (done),
    .eq    (eq),
    .lt    (lt),
    .gt    (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one compare; lat counts cycles from the start-asserted cycle to the done cycle.
  task automatic run_cmp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vs, input logic [2:0] exp_elg, input int exp_lat,
                         input bit disturb);
    int  lat;
    bit  seen;
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    a = va; b = vb; sgn = vs; start = 1'b1;
    step();
    start = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (disturb) begin
        start = 1'b1;
        a = ~va;
        b = 32'h0;
        sgn = ~vs;
      end
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".elg"}, {29'd0, eq, lt, gt}, {29'd0, exp_elg});
    step();
    chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(ready), 32'd1);
    chk({tag, ".hold"}, {29'd0, eq, lt, gt}, {29'd0, exp_elg});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
    step();
    step();
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.elg", {29'd0, eq, lt, gt}, 32'd0);
    rst = 1'b0;
    step();

    // {eq,lt,gt}
    run_cmp("u_eq",    32'h12345678, 32'h12345678, 1'b0, 3'b100, 9, 1'b0);
    run_cmp("u_early", 32'h90000000, 32'h80000000, 1'b0, 3'b001, 2, 1'b0);
    run_cmp("s_neg1",  32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b010, 2, 1'b0);
    run_cmp("u_ff",    32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b001, 2, 1'b0);
    run_cmp("mid",     32'h00000005, 32'h00000003, 1'b0, 3'b001, 9, 1'b1);
    run_cmp("u_idx4",  32'h12340000, 32'h12350000, 1'b0, 3'b010, 5, 1'b0);
    run_cmp("s_min",   32'h80000000, 32'hFFFFFFFF, 1'b1, 3'b010, 2, 1'b0);
    run_cmp("s_eq",    32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b100, 9, 1'b0);

    // Back-to-back: the second start lands in the first IDLE cycle after DONE.
    run_cmp("b2b_1",   32'h00000010, 32'h00000020, 1'b0, 3'b010, 8, 1'b0);
    run_cmp("b2b_2",   32'hA0000000, 32'h00000000, 1'b0, 3'b001, 2, 1'b0);

    // Reset during the 4th SCAN cycle aborts without a done pulse.
    a = 32'hCAFEF00D; b = 32'hCAFEF00D; sgn = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_mid.scan", 32'(ready), 32'd0);
    step();
    step();
    step();
    chk("rst_mid.still_scan", 32'(ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid.ready", 32'(ready), 32'd1);
    chk("rst_mid.done", 32'(done), 32'd0);
    chk("rst_mid.elg", {29'd0, eq, lt, gt}, 32'd0);
    begin
      bit any_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (done) any_done = 1'b1;
      end
      chk("rst_mid.no_done", 32'(any_done), 32'd0);
    end
    run_cmp("post_rst", 32'h00000001, 32'h00000002, 1'b0, 3'b010, 9, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/compare_seq.md
COMPARE_SEQ -- requirements
Module: compare_seq

Interface
REQ-001 Parameter N SHALL be 32: operand width in bits.
REQ-002 Parameter W SHALL be 4: slice width compared per cycle; N SHALL be a multiple of W; S = N/W slices.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a compare; accepted only when ready=1.
REQ-006 a  input  N  operand A; sampled at accept.
REQ-007 b  input  N  operand B; sampled at accept.
REQ-008 sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled at accept.
REQ-009 ready  output  1  block idle and able to accept start.
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 eq  output  1  A == B.
REQ-012 lt  output  1  A < B.
REQ-013 gt  output  1  A > B.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, DONE; ready SHALL be 1 only in IDLE.
REQ-015 IDLE with start=1: latch a, b, sgn; set slice index to S-1 (MS slice); clear eq/lt/gt; go to SCAN.
REQ-016 IDLE with start=0: remain in IDLE.
REQ-017 Signed mode: operand MSBs SHALL be inverted at latch time; all later comparison is unsigned on the latched values.
REQ-018 SCAN: each cycle, compare the latched A and B slices at the current index; one slice per cycle.
REQ-019 Slices differ: set gt if the A slice > the B slice, else set lt; go to DONE.
REQ-020 Slices equal at index 0: set eq; go to DONE.
REQ-021 Slices equal at index >0: decrement index; stay in SCAN.
REQ-022 Early termination SHALL occur at the first differing slice; remaining slices SHALL not be examined.
REQ-023 DONE: assert done for exactly one cycle; then go to IDLE.
REQ-024 Latency: if start is accepted at edge t and k slices are examined (1..S), done SHALL be high in the cycle after edge t+k.
REQ-025 The maximum start-to-done latency SHALL be S+1 = 9 cycles.
REQ-026 When done=1, exactly one of eq/lt/gt SHALL be 1.
REQ-027 eq/lt/gt SHALL hold their values until the next accepted start.
REQ-028 start while ready=0 SHALL be ignored; it SHALL not be queued.
REQ-029 Changes on a, b, sgn after accept SHALL not affect the result.
REQ-030 Back-to-back: a start asserted in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-031 rst=1 SHALL force IDLE with ready=1, done=0, eq=0, lt=0, gt=0, index=S-1, latched operands=0.
REQ-032 Reset in SCAN or DONE SHALL abort the operation with no done pulse; rst SHALL have priority over start.

Structure
REQ-033 A shared constants file SHALL hold the FSM state encodings and the N and W defaults.
REQ-034 One sub-module slice_cmp (W-bit a, b -> eq, gt) SHALL be instantiated once and fed by an index mux; eq SHALL be built from per-bit XNOR terms AND-reduced.
REQ-035 The FSM, index counter, operand registers and result registers SHALL reside in compare_seq.

Verification
REQ-036 Unsigned: a=0x12345678, b=0x12345678 -> done after 9 cycles; eq=1, lt=0, gt=0.
REQ-037 Unsigned early exit: a=0x90000000, b=0x80000000 -> done 2 cycles after accept; gt=1.
REQ-038 Signed: a=0xFFFFFFFF (-1), b=0x00000001, sgn=1 -> lt=1; the same operands with sgn=0 -> gt=1.
REQ-039 Mid-scan: a=0x00000005, b=0x00000003 -> gt=1 at 9 cycles; start pulses during SCAN are ignored, a/b toggled after accept do not change the result.
REQ-040 rst asserted at the 4th SCAN cycle -> next cycle ready=1, eq=lt=gt=0, no done pulse; a new start then completes normally.
REQ-041 Back-to-back starts on consecutive IDLE cycles -> two done pulses with correct, independent results.
